// File: rtl/fetch_stage.sv
// fetch_stage: RV32I fetch PC, imem request/response handshake and IF/ID register; optional FETCH_PERF_EN adds perf counters
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_flush,
  input  logic        E_pcsrc,
  input  logic [31:0] E_pc_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        D_valid,
  output logic [31:0] D_instr,
  output logic [31:0] D_pc,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt,
`endif
  output logic [31:0] D_pc_plus4
);

  typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DISCARD} state_t;

  state_t      state, state_nx;
  logic        run;
  logic [31:0] F_pc, resp_pc, hold_instr, hold_pc, d_instr_q;
  logic        fire, ld_resp, ld_hold, ld;

  assign imem_addr = F_pc;
  assign fire      = imem_req & imem_gnt;
  assign ld_resp   = (state == WAIT) & imem_rvalid & !D_stall & !E_pcsrc;
  assign ld_hold   = (state == HOLD) & !D_stall & !E_pcsrc;
  assign ld        = ld_resp | ld_hold;

  // state register; run keeps requests off until the first edge after reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ISSUE;
      run   <= 1'b0;
    end else begin
      state <= state_nx;
      run   <= 1'b1;
    end

  // next state: redirect first, then the normal handshake
  always_comb begin
    state_nx = state;
    if (E_pcsrc)
      state_nx = ((state == WAIT || state == DISCARD) && !imem_rvalid) ? DISCARD : ISSUE;
    else
      case (state)
        ISSUE:   state_nx = fire ? WAIT : ISSUE;
        WAIT:    if (imem_rvalid) state_nx = D_stall ? HOLD : (fire ? WAIT : ISSUE);
        HOLD:    if (!D_stall) state_nx = ISSUE;
        default: if (imem_rvalid) state_nx = ISSUE;
      endcase
  end

  // outputs: request qualification, NOP gating and sequential PC
  always_comb begin
    imem_req   = run & !F_stall & !E_pcsrc &
                 (state == ISSUE | (state == WAIT & imem_rvalid & !D_stall));
    D_instr    = D_valid ? d_instr_q : NOP_INSTR;
    D_pc_plus4 = D_pc + 32'd4;
  end

  // fetch PC advances on grant; resp_pc remembers the address in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      F_pc    <= RESET_PC;
      resp_pc <= RESET_PC;
    end else if (E_pcsrc) begin
      F_pc <= E_pc_target & ~32'd3;
    end else if (fire) begin
      F_pc    <= F_pc + 32'd4;
      resp_pc <= F_pc;
    end

  // skid register catches a response that arrives while decode is stalled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold_instr <= NOP_INSTR;
      hold_pc    <= 32'd0;
    end else if (state == WAIT && imem_rvalid && D_stall) begin
      hold_instr <= imem_rdata;
      hold_pc    <= resp_pc;
    end

  // IF/ID register: flush beats stall beats load; an unstalled cycle without a load is a bubble
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      D_valid   <= 1'b0;
      d_instr_q <= NOP_INSTR;
      D_pc      <= 32'd0;
    end else if (D_flush) begin
      D_valid <= 1'b0;
    end else if (!D_stall) begin
      D_valid <= ld;
      if (ld) begin
        d_instr_q <= ld_hold ? hold_instr : imem_rdata;
        D_pc      <= ld_hold ? hold_pc : resp_pc;
      end
    end

`ifdef FETCH_PERF_EN
  // perf counters: real IF/ID loads and unstalled empty cycles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_fetch_cnt  <= 32'd0;
      perf_bubble_cnt <= 32'd0;
    end else begin
      if (ld && !D_flush) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (!D_stall && !(ld && !D_flush)) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized bench for fetch_stage with a memory model and an in-order fetch-stream reference
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        F_stall = 0, D_stall = 0, D_flush = 0, E_pcsrc = 0;
  logic [31:0] E_pc_target = 0;
  logic        imem_req, imem_gnt = 0, imem_rvalid = 0;
  logic [31:0] imem_addr, imem_rdata = 0;
  logic        D_valid;
  logic [31:0] D_instr, D_pc, D_pc_plus4;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
`endif

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .F_stall(F_stall), .D_stall(D_stall), .D_flush(D_flush),
    .E_pcsrc(E_pcsrc), .E_pc_target(E_pc_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .D_valid(D_valid), .D_instr(D_instr), .D_pc(D_pc),
`ifdef FETCH_PERF_EN
    .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt),
`endif
    .D_pc_plus4(D_pc_plus4)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // memory model and fetch-stream reference
  bit          pend = 0;
  logic [31:0] pend_addr = 0;
  int          pend_dly = 0;
  int          gnt_pct = 100, min_dly = 0, max_dly = 0;
  logic [31:0] exp_fetch = 0;
  logic [31:0] q[$];
  bit          last_req, last_acc;
  int          n_del = 0;

  // one clock cycle: drive at the negedge, sample mid-cycle, check after the posedge
  task automatic cyc(input bit fs, input bit ds, input bit fl, input bit pcs, input logic [31:0] tgt);
    logic [31:0] pi, pp, a, e;
    bit pv, rv;
    F_stall = fs; D_stall = ds; D_flush = fl; E_pcsrc = pcs; E_pc_target = tgt;
    imem_gnt = $urandom_range(99) < gnt_pct;
    rv = pend && pend_dly == 0;
    imem_rvalid = rv;
    imem_rdata = rv ? mem(pend_addr) : $urandom;
    #1;
    pv = D_valid; pi = D_instr; pp = D_pc; a = imem_addr;
    last_req = imem_req;
    last_acc = imem_req & imem_gnt;
    if (pcs) chk("req_in_redirect", 32'(imem_req), 0);
    if (last_acc) begin
      chk("req_addr", a, exp_fetch);
      chk("one_outstanding", 32'(pend && !rv), 0);
    end
    @(negedge clk);
    if (rv) pend = 0;
    else if (pend && pend_dly > 0) pend_dly--;
    if (last_acc) begin
      pend = 1; pend_addr = a; pend_dly = $urandom_range(max_dly, min_dly);
      q.push_back(a);
      exp_fetch = a + 32'd4;
    end
    if (pcs) begin
      q.delete();
      exp_fetch = tgt & ~32'd3;
    end
    if (fl) begin
      chk("flush_valid", 32'(D_valid), 0);
      chk("flush_nop", D_instr, NOP);
    end else if (ds) begin
      chk("stall_valid", 32'(D_valid), 32'(pv));
      chk("stall_pc", D_pc, pp);
      chk("stall_instr", D_instr, pi);
    end else if (D_valid) begin
      chk("deliver_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("deliver_pc", D_pc, e);
        chk("deliver_instr", D_instr, mem(e));
        chk("deliver_pc4", D_pc_plus4, e + 32'd4);
        n_del++;
      end
    end else chk("bubble_nop", D_instr, NOP);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0);
  endtask

  // bounded wait for the next delivered instruction
  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20; i++) begin
      idle();
      if (D_valid) return;
    end
    chk(tag, 32'(D_valid), 1);
  endtask

  initial begin
    logic [31:0] saved;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(D_valid), 0);
    chk("rst_instr", D_instr, NOP);
    chk("rst_pc", D_pc, 0);
    chk("rst_pc4", D_pc_plus4, 4);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", imem_addr, 0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetch", perf_fetch_cnt, 0);
    chk("rst_perf_bubble", perf_bubble_cnt, 0);
`endif
    rst_n = 1;

    // sequential fetch, zero-wait memory
    for (int i = 0; i < 5 && !last_req; i++) idle();
    chk("lat_req_seen", 32'(last_req), 1);
    chk("lat_edge1", 32'(D_valid), 0);
    idle();
    chk("lat_edge2", 32'(D_valid), 1);
    chk("lat_first_pc", D_pc, 0);
    for (int i = 0; i < 6; i++) begin
      idle();
      chk("throughput", 32'(D_valid), 1);
    end

    // load-use stall into HOLD, then release
    saved = D_pc;
    repeat (3) cyc(1, 1, 0, 0, 0);
    idle();
    chk("hold_valid", 32'(D_valid), 1);
    chk("hold_pc", D_pc, saved + 32'd4);

    // redirect while a slow response is in flight
    min_dly = 2; max_dly = 2;
    for (int i = 0; i < 10; i++) begin
      idle();
      if (last_acc) break;
    end
    cyc(0, 0, 1, 1, 32'h0000_0100);
    chk("redir_valid", 32'(D_valid), 0);
    wait_valid("redir_timeout");
    chk("redir_pc", D_pc, 32'h0000_0100);
    min_dly = 0; max_dly = 0;

    // flush and stall together
    cyc(0, 1, 1, 1, 32'h0000_0200);
    chk("flst_valid", 32'(D_valid), 0);
    chk("flst_instr", D_instr, 32'h0000_0013);

    // PC wrap
    cyc(0, 0, 1, 1, 32'hFFFF_FFFC);
    wait_valid("wrap_timeout");
    chk("wrap_pc", D_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", D_pc_plus4, 0);
    idle();
    chk("wrap_next_valid", 32'(D_valid), 1);
    chk("wrap_next_pc", D_pc, 0);

    // misaligned redirect target
    cyc(0, 0, 1, 1, 32'h0000_0303);
    wait_valid("misalign_timeout");
    chk("misalign_pc", D_pc, 32'h0000_0300);

    // randomized traffic
    gnt_pct = 70; max_dly = 3;
    n_del = 0;
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = $urandom_range(99) < 5;
      cyc($urandom_range(99) < 15, $urandom_range(99) < 15, r, r, $urandom);
    end
    chk("progress", 32'(n_del > 200), 1);

    // asynchronous reset while waiting on a response
    gnt_pct = 100; min_dly = 3; max_dly = 3;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (last_acc) break;
    end
    F_stall = 0; D_stall = 0; D_flush = 0; E_pcsrc = 0; imem_rvalid = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_valid", 32'(D_valid), 0);
    chk("arst_instr", D_instr, NOP);
    chk("arst_pc", D_pc, 0);
    chk("arst_pc4", D_pc_plus4, 4);
    chk("arst_req", 32'(imem_req), 0);
    chk("arst_addr", imem_addr, 0);
`ifdef FETCH_PERF_EN
    chk("arst_perf_fetch", perf_fetch_cnt, 0);
    chk("arst_perf_bubble", perf_bubble_cnt, 0);
`endif
    pend = 0; q.delete(); exp_fetch = 0;
    min_dly = 0; max_dly = 0;
    @(negedge clk);
    rst_n = 1;
    wait_valid("post_rst_timeout");
    chk("post_rst_pc", D_pc, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
